// File: rtl/pwm_gen.sv
// Two-channel PWM generator driven by an external free-running counter; duty changes take effect only at counter wrap.
// Optional sticky period interrupt is built when PWM_GEN_IRQ_EN is defined.
module pwm_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DUTY = WIDTH'(8'h80),
    parameter logic             POLARITY   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic             duty_wr,
    input  logic             duty_sel,
    input  logic [WIDTH-1:0] duty_data,
    input  logic             irq_clr,
    output logic [1:0]       pwm,
    output logic             wrap,
    output logic             irq
);

    logic [WIDTH-1:0]       prev_count_q, prev_count_d;
    logic [1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [1:0][WIDTH-1:0]  active_q, active_d;
    logic [1:0][WIDTH-1:0]  duty_eff;
    logic [1:0]             on;
    logic [1:0]             pwm_q, pwm_d;
    logic                   wrap_q, wrap_d;
    logic                   wrap_w;

    // Only a clean max->0 step counts as a wrap; an upstream reset to 0 mid-period does not.
    assign wrap_w = (prev_count_q == {WIDTH{1'b1}}) && (count == '0);

    always_comb begin
        prev_count_d = count;
        shadow_d     = shadow_q;
        if (duty_wr) begin
            shadow_d[duty_sel] = duty_data;
        end
        active_d = wrap_w ? shadow_q : active_q;
        duty_eff = '0;
        on       = '0;
        pwm_d    = '0;
        for (int n = 0; n < 2; n++) begin
            // Count 0 of a new period already compares against the promoted duty.
            duty_eff[n] = wrap_w ? shadow_q[n] : active_q[n];
            on[n]       = count < duty_eff[n];
            pwm_d[n]    = enable ? (on[n] ~^ POLARITY) : ~POLARITY;
        end
        wrap_d = wrap_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count_q <= '0;
            shadow_q     <= {2{RESET_DUTY}};
            active_q     <= {2{RESET_DUTY}};
            pwm_q        <= {2{~POLARITY}};
            wrap_q       <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pwm_q        <= pwm_d;
            wrap_q       <= wrap_d;
        end
    end

    assign pwm  = pwm_q;
    assign wrap = wrap_q;

`ifdef PWM_GEN_IRQ_EN
    logic irq_q, irq_d;

    // Set has priority over clear so a wrap is never lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (wrap_w) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: a table of count-range segments with hand-computed duties,
// plus hand-written reset sequences.
module tb_pwm_gen;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic       enable;
  logic       duty_wr;
  logic       duty_sel;
  logic [7:0] duty_data;
  logic       irq_clr;
  logic [1:0] pwm;
  logic       wrap;
  logic       irq;

`ifdef PWM_GEN_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  int n_checks;
  int n_pass;

  pwm_gen #(
    .WIDTH(8),
    .RESET_DUTY(8'h80),
    .POLARITY(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .count(count),
    .enable(enable),
    .duty_wr(duty_wr),
    .duty_sel(duty_sel),
    .duty_data(duty_data),
    .irq_clr(irq_clr),
    .pwm(pwm),
    .wrap(wrap),
    .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One segment: counts c_lo..c_hi in order; wr/clr only on the first cycle;
  // exp_wrap applies to the first cycle only; d0/d1 are the thresholds in force.
  typedef struct {
    logic [7:0] c_lo;
    logic [7:0] c_hi;
    logic       en;
    logic       wr;
    logic       sel;
    logic [7:0] data;
    logic       clr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_wrap;
    logic       exp_irq;
  } seg_t;

  seg_t segs[14];

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // driver: apply inputs at negedge, sample #1 after the next posedge
  task automatic drive(input logic [7:0] c, input logic en, input logic wr, input logic sel,
                       input logic [7:0] data, input logic clr, input logic rst);
    @(negedge clk);
    count     = c;
    enable    = en;
    duty_wr   = wr;
    duty_sel  = sel;
    duty_data = data;
    irq_clr   = clr;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_pwm;
    logic       first;
    n_checks = 0;
    n_pass   = 0;
    count = 8'h00; enable = 1'b1; duty_wr = 1'b0; duty_sel = 1'b0;
    duty_data = 8'h00; irq_clr = 1'b0; reset = 1'b1;

    //            lo     hi    en    wr    sel   data   clr   d0     d1     wrap  irq
    segs[0]  = '{8'h00, 8'h3F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0};
    segs[1]  = '{8'h40, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0};
    segs[2]  = '{8'h00, 8'h04, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h10, 8'h80, 1'b1, 1'b1};
    segs[3]  = '{8'h05, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h80, 1'b0, 1'b0};
    segs[4]  = '{8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 1'b1};
    segs[5]  = '{8'h10, 8'h1F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0};
    segs[6]  = '{8'h20, 8'h37, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0};
    segs[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0};
    segs[8]  = '{8'h00, 8'h3F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1};
    segs[9]  = '{8'h40, 8'h4F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1};
    segs[10] = '{8'h50, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h60, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1};
    segs[11] = '{8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h60, 1'b1, 1'b1};
    segs[12] = '{8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h60, 1'b0, 1'b1};
    segs[13] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h60, 1'b1, 1'b1};

    // reset state
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_pwm", 0, {6'd0, pwm}, 8'h00);
    check("reset_wrap", 0, {7'd0, wrap}, 8'h00);
    check("reset_irq", 0, {7'd0, irq}, 8'h00);

    for (int s = 0; s < 14; s++) begin
      for (int c = int'(segs[s].c_lo); c <= int'(segs[s].c_hi); c++) begin
        first = (c == int'(segs[s].c_lo));
        drive(8'(c), segs[s].en, first & segs[s].wr, segs[s].sel, segs[s].data,
              first & segs[s].clr, 1'b0);
        exp_pwm = segs[s].en ? {c < int'(segs[s].d1), c < int'(segs[s].d0)} : 2'b00;
        check("seg_pwm", s * 1000 + c, {6'd0, pwm}, {6'd0, exp_pwm});
        check("seg_wrap", s * 1000 + c, {7'd0, wrap}, {7'd0, first & segs[s].exp_wrap});
        check("seg_irq", s * 1000 + c, {7'd0, irq}, {7'd0, IRQ_BUILT & segs[s].exp_irq});
      end
    end

    // reset overrides a wrap and all other inputs on the same edge
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1);
    check("rst_ovr_pwm", 0, {6'd0, pwm}, 8'h00);
    check("rst_ovr_wrap", 0, {7'd0, wrap}, 8'h00);
    check("rst_ovr_irq", 0, {7'd0, irq}, 8'h00);

    // first sample after reset cannot wrap; duties are back to 0x80
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_wrap", 0, {7'd0, wrap}, 8'h00);
    check("post_rst_pwm", 0, {6'd0, pwm}, 8'h03);
    drive(8'h7F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_7f", 0, {6'd0, pwm}, 8'h03);
    drive(8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_80", 0, {6'd0, pwm}, 8'h00);

    // burst writes: the last write before the wrap is promoted
    drive(8'hFD, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    drive(8'hFE, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("burst_wrap", 0, {7'd0, wrap}, 8'h01);
    check("burst_c00", 0, {6'd0, pwm}, 8'h03);
    drive(8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("burst_c02", 0, {6'd0, pwm}, 8'h03);
    drive(8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("burst_c03", 0, {6'd0, pwm}, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
